// File: rtl/johnson8_decoder.sv
// johnson8_decoder
//   Receive-side checker for an 8-bit Johnson-coded state bus. Each strobed
//   sample is decoded to its binary position (0..15), checked for legality,
//   and checked against the counter sequence. A HUNT/LOCKED tracker and a
//   saturating error counter summarise the health of the bus.
//
// Ports
//   CLK      in   clock, rising edge
//   RESET    in   asynchronous reset, active-high
//   EN       in   sample strobe; Q_IN is evaluated only when EN=1
//   Q_IN     in   8-bit Johnson code under test
//   COUNT    out  decoded position of the last legal sample
//   VALID    out  pulse: COUNT updated from a legal sample
//   ILLEGAL  out  pulse: sample is not one of the 16 Johnson codes
//   SEQ_ERR  out  pulse: legal code but not the expected successor (LOCKED)
//   LOCKED   out  tracker is in LOCKED
//   ERR_CNT  out  saturating count of ILLEGAL + SEQ_ERR events
module johnson8_decoder #(
  parameter int LOCK_CNT   = 2,
  parameter int ERR_W      = 8,
  parameter int ALLOW_HOLD = 0
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             EN,
  input  logic [7:0]       Q_IN,
  output logic [3:0]       COUNT,
  output logic             VALID,
  output logic             ILLEGAL,
  output logic             SEQ_ERR,
  output logic             LOCKED,
  output logic [ERR_W-1:0] ERR_CNT
);

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED_ST = 1'b1
  } state_t;

  function automatic logic [3:0] popcnt(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

  // A legal code is a run of ones then zeros (MSB=1) or zeros then ones
  // (MSB=0). Folding the MSB=1 case through inversion leaves a pattern of
  // the form 0..01..1, which is exactly the values where r & (r+1) == 0.
  function automatic logic is_legal(input logic [7:0] q);
    logic [7:0] r;
    r = q[7] ? ~q : q;
    return ((r + 8'd1) & r) == 8'd0;
  endfunction

  function automatic logic [3:0] decode_pos(input logic [7:0] q);
    return q[7] ? (4'd8 - popcnt(q)) : (4'd8 + popcnt(q));
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t           state_q,    state_d;
  logic [3:0]       count_q,    count_d;
  logic             valid_q,    valid_d;
  logic             illegal_q,  illegal_d;
  logic             seq_err_q,  seq_err_d;
  logic [ERR_W-1:0] err_cnt_q,  err_cnt_d;
  logic [3:0]       run_q,      run_d;
  logic [3:0]       prev_pos_q, prev_pos_d;
  logic             prev_vld_q, prev_vld_d;

  logic       legal;
  logic [3:0] pos;
  logic [3:0] succ;
  logic       in_seq;
  logic       repeat_code;

  assign legal       = is_legal(Q_IN);
  assign pos         = decode_pos(Q_IN);
  assign succ        = prev_pos_q + 4'd1;
  assign in_seq      = prev_vld_q && (pos == succ);
  assign repeat_code = prev_vld_q && (pos == prev_pos_q);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    valid_d    = 1'b0;
    illegal_d  = 1'b0;
    seq_err_d  = 1'b0;
    err_cnt_d  = err_cnt_q;
    run_d      = run_q;
    prev_pos_d = prev_pos_q;
    prev_vld_d = prev_vld_q;

    if (EN) begin
      if (!legal) begin
        illegal_d  = 1'b1;
        err_cnt_d  = sat_inc(err_cnt_q);
        prev_vld_d = 1'b0;
        run_d      = 4'd0;
        state_d    = HUNT;
      end else begin
        count_d    = pos;
        valid_d    = 1'b1;
        prev_pos_d = pos;
        prev_vld_d = 1'b1;
        if (state_q == HUNT) begin
          // A stall in HUNT neither extends nor breaks the run when holds
          // are allowed; otherwise any break in sequence restarts it.
          if (!prev_vld_q || in_seq) run_d = run_q + 4'd1;
          else if (repeat_code && (ALLOW_HOLD != 0)) run_d = run_q;
          else run_d = 4'd1;
          if (run_d >= 4'(LOCK_CNT)) state_d = LOCKED_ST;
        end else begin
          if (!(in_seq || (repeat_code && (ALLOW_HOLD != 0)))) begin
            seq_err_d = 1'b1;
            err_cnt_d = sat_inc(err_cnt_q);
            run_d     = 4'd1;
            state_d   = HUNT;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= HUNT;
      count_q    <= 4'd0;
      valid_q    <= 1'b0;
      illegal_q  <= 1'b0;
      seq_err_q  <= 1'b0;
      err_cnt_q  <= '0;
      run_q      <= 4'd0;
      prev_pos_q <= 4'd0;
      prev_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      illegal_q  <= illegal_d;
      seq_err_q  <= seq_err_d;
      err_cnt_q  <= err_cnt_d;
      run_q      <= run_d;
      prev_pos_q <= prev_pos_d;
      prev_vld_q <= prev_vld_d;
    end
  end

  assign COUNT   = count_q;
  assign VALID   = valid_q;
  assign ILLEGAL = illegal_q;
  assign SEQ_ERR = seq_err_q;
  assign LOCKED  = (state_q == LOCKED_ST);
  assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_johnson8_decoder.sv
// Testbench for johnson8_decoder: three instances (default, ALLOW_HOLD=1,
// ERR_W=2) share clock, reset and data, each with its own strobe. Expected
// responses are queued as samples are issued; monitors pop and compare each
// time an instance presents VALID or ILLEGAL.
module tb_johnson8_decoder;

  typedef struct packed {
    logic [3:0] count;
    logic       valid;
    logic       illegal;
    logic       seq_err;
    logic       locked;
    logic [7:0] err;
  } exp_t;

  logic       CLK;
  logic       RESET;
  logic       en0, enh, ene;
  logic [7:0] Q_IN;

  logic [3:0] count0, counth, counte;
  logic       valid0, validh, valide;
  logic       ill0, illh, ille;
  logic       seq0, seqh, seqe;
  logic       lk0, lkh, lke;
  logic [7:0] err0, errh;
  logic [1:0] erre;

  int checks = 0;
  int errors = 0;

  exp_t q0[$];
  exp_t qh[$];
  exp_t qe[$];

  johnson8_decoder #(.LOCK_CNT(2), .ERR_W(8), .ALLOW_HOLD(0)) dut0 (
    .CLK(CLK), .RESET(RESET), .EN(en0), .Q_IN(Q_IN),
    .COUNT(count0), .VALID(valid0), .ILLEGAL(ill0), .SEQ_ERR(seq0),
    .LOCKED(lk0), .ERR_CNT(err0)
  );

  johnson8_decoder #(.LOCK_CNT(2), .ERR_W(8), .ALLOW_HOLD(1)) duth (
    .CLK(CLK), .RESET(RESET), .EN(enh), .Q_IN(Q_IN),
    .COUNT(counth), .VALID(validh), .ILLEGAL(illh), .SEQ_ERR(seqh),
    .LOCKED(lkh), .ERR_CNT(errh)
  );

  johnson8_decoder #(.LOCK_CNT(2), .ERR_W(2), .ALLOW_HOLD(0)) dute (
    .CLK(CLK), .RESET(RESET), .EN(ene), .Q_IN(Q_IN),
    .COUNT(counte), .VALID(valide), .ILLEGAL(ille), .SEQ_ERR(seqe),
    .LOCKED(lke), .ERR_CNT(erre)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic exp_t mk(input int c, input bit v, input bit i,
                              input bit s, input bit l, input int e);
    exp_t x;
    x.count   = 4'(c);
    x.valid   = v;
    x.illegal = i;
    x.seq_err = s;
    x.locked  = l;
    x.err     = 8'(e);
    return x;
  endfunction

  task automatic compare(input string nm, input exp_t got, input exp_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got cnt=%0d v=%0b ill=%0b seq=%0b lk=%0b err=%0d, expected cnt=%0d v=%0b ill=%0b seq=%0b lk=%0b err=%0d",
               nm, got.count, got.valid, got.illegal, got.seq_err, got.locked, got.err,
               exp.count, exp.valid, exp.illegal, exp.seq_err, exp.locked, exp.err);
    end
  endtask

  function automatic exp_t out0();
    return mk(int'(count0), valid0, ill0, seq0, lk0, int'(err0));
  endfunction
  function automatic exp_t outh();
    return mk(int'(counth), validh, illh, seqh, lkh, int'(errh));
  endfunction
  function automatic exp_t oute();
    return mk(int'(counte), valide, ille, seqe, lke, int'(erre));
  endfunction

  // Monitors: each VALID/ILLEGAL presentation consumes one expected entry.
  always @(negedge CLK) begin
    if (valid0 || ill0) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL dut0_spurious: output pulse with no sample outstanding (cnt=%0d)", count0);
      end else compare("dut0_sample", out0(), q0.pop_front());
    end
  end

  always @(negedge CLK) begin
    if (validh || illh) begin
      if (qh.size() == 0) begin
        checks++; errors++;
        $display("FAIL hold_spurious: output pulse with no sample outstanding (cnt=%0d)", counth);
      end else compare("hold_sample", outh(), qh.pop_front());
    end
  end

  always @(negedge CLK) begin
    if (valide || ille) begin
      if (qe.size() == 0) begin
        checks++; errors++;
        $display("FAIL errw_spurious: output pulse with no sample outstanding (cnt=%0d)", counte);
      end else compare("errw_sample", oute(), qe.pop_front());
    end
  end

  task automatic samp(input int which, input logic [7:0] q, input exp_t e);
    @(negedge CLK);
    en0  = (which == 0);
    enh  = (which == 1);
    ene  = (which == 2);
    Q_IN = q;
    case (which)
      0: q0.push_back(e);
      1: qh.push_back(e);
      default: qe.push_back(e);
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      en0 = 1'b0; enh = 1'b0; ene = 1'b0;
    end
  endtask

  task automatic drain_check(input string nm, input int sz);
    checks++;
    if (sz != 0) begin
      errors++;
      $display("FAIL %s: %0d expected responses never presented, required 0", nm, sz);
    end
  endtask

  initial begin
    RESET = 1'b1; en0 = 1'b0; enh = 1'b0; ene = 1'b0; Q_IN = 8'h00;
    repeat (2) @(negedge CLK);
    compare("reset_dut0", out0(), mk(0, 0, 0, 0, 0, 0));
    compare("reset_errw", oute(), mk(0, 0, 0, 0, 0, 0));
    RESET = 1'b0;

    // Lock-up, wrap, illegal recovery, sequence errors, repeats (hold off).
    samp(0, 8'hFF, mk( 0, 1, 0, 0, 0, 0));
    samp(0, 8'hFE, mk( 1, 1, 0, 0, 1, 0));
    samp(0, 8'hFC, mk( 2, 1, 0, 0, 1, 0));
    samp(0, 8'h3F, mk(14, 1, 0, 1, 0, 1));
    samp(0, 8'h7F, mk(15, 1, 0, 0, 1, 1));
    samp(0, 8'hFF, mk( 0, 1, 0, 0, 1, 1));
    samp(0, 8'hFE, mk( 1, 1, 0, 0, 1, 1));
    samp(0, 8'h07, mk(11, 1, 0, 1, 0, 2));
    samp(0, 8'h0F, mk(12, 1, 0, 0, 1, 2));
    samp(0, 8'h5A, mk(12, 0, 1, 0, 0, 3));
    samp(0, 8'h1F, mk(13, 1, 0, 0, 0, 3));
    samp(0, 8'h3F, mk(14, 1, 0, 0, 1, 3));
    samp(0, 8'h01, mk( 9, 1, 0, 1, 0, 4));
    samp(0, 8'h03, mk(10, 1, 0, 0, 1, 4));
    samp(0, 8'hF0, mk( 4, 1, 0, 1, 0, 5));
    samp(0, 8'hE0, mk( 5, 1, 0, 0, 1, 5));
    samp(0, 8'hC0, mk( 6, 1, 0, 0, 1, 5));
    samp(0, 8'hC0, mk( 6, 1, 0, 1, 0, 6));
    samp(0, 8'hC0, mk( 6, 1, 0, 0, 0, 6));
    samp(0, 8'h80, mk( 7, 1, 0, 0, 1, 6));
    idle(3);
    compare("idle_hold_dut0", out0(), mk(7, 0, 0, 0, 1, 6));

    // Hold-allowed instance: repeats are stalls while LOCKED.
    samp(1, 8'hFF, mk(0, 1, 0, 0, 0, 0));
    samp(1, 8'hFE, mk(1, 1, 0, 0, 1, 0));
    samp(1, 8'hFE, mk(1, 1, 0, 0, 1, 0));
    samp(1, 8'hFE, mk(1, 1, 0, 0, 1, 0));
    samp(1, 8'hFC, mk(2, 1, 0, 0, 1, 0));
    samp(1, 8'h00, mk(8, 1, 0, 1, 0, 1));

    // Narrow error counter saturates at 3.
    samp(2, 8'h5A, mk(0, 0, 1, 0, 0, 1));
    samp(2, 8'h81, mk(0, 0, 1, 0, 0, 2));
    samp(2, 8'h7E, mk(0, 0, 1, 0, 0, 3));
    samp(2, 8'h55, mk(0, 0, 1, 0, 0, 3));
    samp(2, 8'hAA, mk(0, 0, 1, 0, 0, 3));
    samp(2, 8'hFF, mk(0, 1, 0, 0, 0, 3));
    idle(3);

    // Reset between clock edges takes effect without a clock.
    @(posedge CLK);
    #2 RESET = 1'b1;
    #1;
    compare("async_reset_dut0", out0(), mk(0, 0, 0, 0, 0, 0));
    compare("async_reset_hold", outh(), mk(0, 0, 0, 0, 0, 0));
    compare("async_reset_errw", oute(), mk(0, 0, 0, 0, 0, 0));
    @(negedge CLK);
    RESET = 1'b0;

    // First sample after release starts a fresh HUNT run.
    samp(0, 8'hFE, mk(1, 1, 0, 0, 0, 0));
    samp(0, 8'hFC, mk(2, 1, 0, 0, 1, 0));
    idle(4);

    drain_check("drain_dut0", q0.size());
    drain_check("drain_hold", qh.size());
    drain_check("drain_errw", qe.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
